fft_out_streamer: RTL and testbench

FFT_OUT_STREAMER -- requirements
Module: fft_out_streamer

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_out_streamer_if.sv | 29 ++
 rtl/fft_sat8.sv | 35 +++
 rtl/fft_out_streamer.sv | 141 ++++++++++++++
 tb/tb_fft_out_streamer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT result streamer.
// Optional magnitude mode is selected by the FFT_OUT_MAG_EN macro.
package fft_pkg;

  localparam int N_BINS_DEF = 8;
  localparam int DW_DEF     = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND_RE,
    SEND_IM,
    FINISH
  } state_t;

  // Clamp a sign-extended value into the signed 8-bit range.
  function automatic logic [7:0] sat8(input logic signed [63:0] v);
    if (v > 64'sd127) begin
      return 8'h7F;
    end else if (v < -64'sd128) begin
      return 8'h80;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/fft_out_streamer_if.sv
// Result-buffer read port plus byte-stream handshake of the FFT streamer.
// Identical in both builds (FFT_OUT_MAG_EN on or off).
interface fft_out_streamer_if
  import fft_pkg::*;
#(
  parameter int N_BINS = N_BINS_DEF,
  parameter int DW     = DW_DEF
);
  localparam int AW = $clog2(N_BINS);

  logic                 rd_en;
  logic [AW-1:0]        rd_addr;
  logic signed [DW-1:0] rd_re;
  logic signed [DW-1:0] rd_im;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 frame_start;

  modport master (
    output rd_en, rd_addr, tx_data, tx_valid, frame_start,
    input  rd_re, rd_im, tx_ready
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_valid, frame_start,
    output rd_re, rd_im, tx_ready
  );
endinterface

// File: rtl/fft_sat8.sv
// Converts a DW-bit complex result word to output bytes.
// FFT_OUT_MAG_EN: one byte |re|+|im| clamped to 255; otherwise re/im each saturated to signed 8 bits.
module fft_sat8
  import fft_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
`ifdef FFT_OUT_MAG_EN
  output logic [7:0]           mag_byte
`else
  output logic [7:0]           re_byte,
  output logic [7:0]           im_byte
`endif
);

`ifdef FFT_OUT_MAG_EN
  logic [DW-1:0] abs_re;
  logic [DW-1:0] abs_im;
  logic [DW:0]   mag_sum;

  // Unsigned DW bits hold |-2^(DW-1)| exactly, so the sum never overflows DW+1.
  always_comb begin
    abs_re   = re[DW-1] ? $unsigned(-re) : $unsigned(re);
    abs_im   = im[DW-1] ? $unsigned(-im) : $unsigned(im);
    mag_sum  = {1'b0, abs_re} + {1'b0, abs_im};
    mag_byte = (32'(mag_sum) > 32'd255) ? 8'hFF : 8'(mag_sum);
  end
`else
  assign re_byte = sat8(64'(re));
  assign im_byte = sat8(64'(im));
`endif

endmodule

// File: rtl/fft_out_streamer.sv
// Streams one FFT result frame out of the result buffer as bytes over a valid/ready pin interface.
// Define FFT_OUT_MAG_EN to send one magnitude byte per bin instead of real/imag pairs.
module fft_out_streamer
  import fft_pkg::*;
#(
  parameter int N_BINS = N_BINS_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  fft_out_streamer_if.master  bus
);

  localparam int AW = $clog2(N_BINS);

`ifdef FFT_OUT_MAG_EN
  localparam state_t LAST_SEND = SEND_RE;
`else
  localparam state_t LAST_SEND = SEND_IM;
`endif

  state_t        state_reg;
  logic [AW-1:0] cnt_reg;
  logic          rd_en_reg;
  logic [AW-1:0] rd_addr_reg;
  logic [7:0]    tx_data_reg;
  logic          tx_valid_reg;
  logic          frame_start_reg;
  logic          busy_reg;
  logic          done_reg;
  logic [7:0]    first_byte;
  logic          last_bin;
  logic          bin_done;

`ifdef FFT_OUT_MAG_EN
  fft_sat8 #(.DW(DW)) u_sat (
    .re       (bus.rd_re),
    .im       (bus.rd_im),
    .mag_byte (first_byte)
  );
`else
  logic [7:0] second_byte;
  logic [7:0] im_byte_reg;

  fft_sat8 #(.DW(DW)) u_sat (
    .re      (bus.rd_re),
    .im      (bus.rd_im),
    .re_byte (first_byte),
    .im_byte (second_byte)
  );
`endif

  assign last_bin = (cnt_reg == AW'(N_BINS - 1));
  // Last byte of the current bin handed over to the reader.
  assign bin_done = tx_valid_reg && bus.tx_ready && (state_reg == LAST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      rd_en_reg       <= 1'b0;
      rd_addr_reg     <= '0;
      tx_data_reg     <= 8'h00;
      tx_valid_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
`ifndef FFT_OUT_MAG_EN
      im_byte_reg     <= 8'h00;
`endif
    end else begin
      rd_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= FETCH;
            cnt_reg     <= '0;
            rd_addr_reg <= '0;
            rd_en_reg   <= 1'b1;
            busy_reg    <= 1'b1;
          end
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          tx_data_reg     <= first_byte;
`ifndef FFT_OUT_MAG_EN
          im_byte_reg     <= second_byte;
`endif
          tx_valid_reg    <= 1'b1;
          frame_start_reg <= (cnt_reg == '0);
          state_reg       <= SEND_RE;
        end
        SEND_RE: begin
`ifndef FFT_OUT_MAG_EN
          if (tx_valid_reg && bus.tx_ready) begin
            tx_data_reg     <= im_byte_reg;
            frame_start_reg <= 1'b0;
            state_reg       <= SEND_IM;
          end
`endif
        end
        SEND_IM: begin
        end
        FINISH: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
        default: state_reg <= IDLE;
      endcase

      // Advance to the next bin, or close the frame after the last one.
      if (bin_done) begin
        tx_valid_reg    <= 1'b0;
        frame_start_reg <= 1'b0;
        if (last_bin) begin
          state_reg <= FINISH;
          done_reg  <= 1'b1;
        end else begin
          cnt_reg     <= cnt_reg + 1'b1;
          rd_addr_reg <= cnt_reg + 1'b1;
          rd_en_reg   <= 1'b1;
          state_reg   <= FETCH;
        end
      end
    end
  end

  assign bus.rd_en       = rd_en_reg;
  assign bus.rd_addr     = rd_addr_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.tx_valid    = tx_valid_reg;
  assign bus.frame_start = frame_start_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;

endmodule

// File: tb/tb_fft_out_streamer.sv
// Randomized self-checking bench for fft_out_streamer against a byte-queue reference model.
// Works in both builds; FFT_OUT_MAG_EN switches the model to magnitude bytes.
module tb_fft_out_streamer;
  import fft_pkg::*;

  localparam int N  = 8;
  localparam int DW = 8;
`ifdef FFT_OUT_MAG_EN
  localparam int FL  = N;
  localparam int FL12 = 2;
`else
  localparam int FL  = 2 * N;
  localparam int FL12 = 4;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic start12 = 1'b0;
  logic busy12, done12;

  always #5 clk = ~clk;

  fft_out_streamer_if #(.N_BINS(N), .DW(DW)) bus_if ();
  fft_out_streamer #(.N_BINS(N), .DW(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus_if)
  );

  fft_out_streamer_if #(.N_BINS(2), .DW(12)) bus12 ();
  fft_out_streamer #(.N_BINS(2), .DW(12)) u_dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start12),
    .busy  (busy12),
    .done  (done12),
    .bus   (bus12)
  );
  assign bus12.tx_ready = 1'b1;

  // Result buffers with one-cycle registered read.
  int mem_re[N];
  int mem_im[N];
  int m12_re[2];
  int m12_im[2];

  always @(posedge clk) begin
    if (bus_if.rd_en) begin
      bus_if.rd_re <= DW'(mem_re[bus_if.rd_addr]);
      bus_if.rd_im <= DW'(mem_im[bus_if.rd_addr]);
    end
    if (bus12.rd_en) begin
      bus12.rd_re <= 12'(m12_re[bus12.rd_addr]);
      bus12.rd_im <= 12'(m12_im[bus12.rd_addr]);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte rules straight from the frame definition.
  function automatic logic [7:0] ref_sat(input int v);
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic logic [7:0] ref_mag(input int re, input int im);
    int s;
    s = (re < 0 ? -re : re) + (im < 0 ? -im : im);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] exp_frame[$];

  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
`ifdef FFT_OUT_MAG_EN
      exp_q.push_back(ref_mag(mem_re[k], mem_im[k]));
`else
      exp_q.push_back(ref_sat(mem_re[k]));
      exp_q.push_back(ref_sat(mem_im[k]));
`endif
    end
    exp_frame = exp_q;
  endtask

  task automatic fill_random();
    for (int k = 0; k < N; k++) begin
      mem_re[k] = int'($urandom_range(0, 255)) - 128;
      mem_im[k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Monitor: scoreboard of accepted bytes, hold stability, done timing.
  int bytes_seen = 0;
  int done_cnt   = 0;
  int cyc        = 0;
  int last_acc   = -10;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_fs;
  logic [7:0] q12[$];
  int         done12_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      bytes_seen = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", bus_if.tx_valid, 1'b1);
        check_val("hold_data", bus_if.tx_data, prev_data);
        check_val("hold_fs", bus_if.frame_start, prev_fs);
      end
      if (bus_if.tx_valid) check_val("busy_in_frame", busy, 1'b1);
      if (bus_if.tx_valid && bus_if.tx_ready) begin
        check_val("byte_within_frame", bytes_seen < FL, 1'b1);
        if (exp_q.size() > 0) begin
          $display("[TB] byte %0d data=%02h fs=%0b", bytes_seen, bus_if.tx_data, bus_if.frame_start);
          check_val("byte_data", bus_if.tx_data, exp_q.pop_front());
        end
        check_val("frame_start", bus_if.frame_start, bytes_seen == 0);
        bytes_seen++;
        last_acc = cyc;
      end
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
      prev_fs    = bus_if.frame_start;
      if (done) begin
        check_val("done_timing", cyc, last_acc + 1);
        check_val("frame_len", bytes_seen, FL);
        bytes_seen = 0;
        done_cnt++;
      end
      if (bus12.tx_valid && bus12.tx_ready) q12.push_back(bus12.tx_data);
      if (done12) done12_cnt++;
    end
  end

  // tx_ready driver: 0 = always ready, 1 = random, 2 = five-cycle stall on byte 3.
  int ready_mode = 0;
  int stall_cnt  = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus_if.tx_ready = 1'b1;
      1: bus_if.tx_ready = 1'($urandom_range(0, 1));
      default: begin
        if (bytes_seen == 3 && stall_cnt < 5) begin
          bus_if.tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          bus_if.tx_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bytes_seen >= n) return;
    end
    check_val("wait_bytes_timeout", bytes_seen, n);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt >= target) return;
    end
    check_val("done_timeout", done_cnt, target);
  endtask

  initial begin
    int lim;
    logic [7:0] e12[$];

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_tx_valid", bus_if.tx_valid, 1'b0);
    check_val("rst_tx_data", bus_if.tx_data, 8'h00);
    check_val("rst_frame_start", bus_if.frame_start, 1'b0);
    check_val("rst_rd_en", bus_if.rd_en, 1'b0);
    check_val("rst_rd_addr", bus_if.rd_addr, 0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    rst_n = 1'b1;

    // Frame 1: re=k, im=-k, always ready, with first-byte latency checks
    for (int k = 0; k < N; k++) begin
      mem_re[k] = k;
      mem_im[k] = -k;
    end
    build_exp();
    ready_mode = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_val("fetch_rd_en", bus_if.rd_en, 1'b1);
    check_val("fetch_rd_addr", bus_if.rd_addr, 0);
    check_val("fetch_busy", busy, 1'b1);
    check_val("fetch_tx_valid", bus_if.tx_valid, 1'b0);
    @(posedge clk);
    #1;
    check_val("load_rd_en", bus_if.rd_en, 1'b0);
    check_val("load_tx_valid", bus_if.tx_valid, 1'b0);
    @(posedge clk);
    #1;
    check_val("first_tx_valid", bus_if.tx_valid, 1'b1);
    check_val("first_frame_start", bus_if.frame_start, 1'b1);
    check_val("first_tx_data", bus_if.tx_data, exp_frame[0]);
    wait_done(1);
    check_val("f1_queue_empty", exp_q.size(), 0);

    // Frame 2: stall on byte 3; start coincident with done must be ignored
    build_exp();
    stall_cnt  = 0;
    ready_mode = 2;
    pulse_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bytes_seen == 3 && stall_cnt >= 3) break;
    end
    check_val("stall_valid", bus_if.tx_valid, 1'b1);
    check_val("stall_data", bus_if.tx_data, exp_frame[3]);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_val("done_seen", done, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_val("start_on_done_rd_en", bus_if.rd_en, 1'b0);
    check_val("start_on_done_busy", busy, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check_val("start_on_done_idle", busy, 1'b0);
    check_val("f2_done_cnt", done_cnt, 2);
    check_val("f2_queue_empty", exp_q.size(), 0);

    // Frame 3: random data and ready, second start during byte 6 ignored
    fill_random();
    build_exp();
    ready_mode = 1;
    pulse_start();
    wait_bytes(6);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3);
    repeat (10) @(posedge clk);
    #1;
    check_val("f3_no_restart_busy", busy, 1'b0);
    check_val("f3_no_restart_valid", bus_if.tx_valid, 1'b0);
    check_val("f3_done_cnt", done_cnt, 3);
    check_val("f3_queue_empty", exp_q.size(), 0);

    // Frame 4: asynchronous reset mid-frame
    fill_random();
    build_exp();
    ready_mode = 0;
    pulse_start();
    wait_bytes(FL * 9 / 16);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", bus_if.tx_valid, 1'b0);
    check_val("async_rst_data", bus_if.tx_data, 8'h00);
    check_val("async_rst_fs", bus_if.frame_start, 1'b0);
    check_val("async_rst_busy", busy, 1'b0);
    check_val("async_rst_rd_addr", bus_if.rd_addr, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check_val("no_resume_valid", bus_if.tx_valid, 1'b0);
    check_val("no_resume_busy", busy, 1'b0);

    // Frame 5: fresh frame after reset, with fixed corner bins
    fill_random();
    mem_re[0] = -100;
    mem_im[0] = 100;
    mem_re[1] = 127;
    mem_im[1] = -128;
    build_exp();
    ready_mode = 1;
    pulse_start();
    wait_done(4);
    check_val("f5_queue_empty", exp_q.size(), 0);

    // DW=12 instance: saturation of wide words
    m12_re[0] = 2032;
    m12_im[0] = -2032;
    m12_re[1] = -5;
    m12_im[1] = 300;
    for (int k = 0; k < 2; k++) begin
`ifdef FFT_OUT_MAG_EN
      e12.push_back(ref_mag(m12_re[k], m12_im[k]));
`else
      e12.push_back(ref_sat(m12_re[k]));
      e12.push_back(ref_sat(m12_im[k]));
`endif
    end
    @(posedge clk);
    #1 start12 = 1'b1;
    @(posedge clk);
    #1 start12 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done12_cnt > 0) break;
    end
    check_val("dw12_done", done12_cnt, 1);
    check_val("dw12_len", q12.size(), FL12);
    lim = (q12.size() < FL12) ? q12.size() : FL12;
    for (int i = 0; i < lim; i++) begin
      $display("[TB] dw12 byte %0d data=%02h", i, q12[i]);
      check_val("dw12_byte", q12[i], e12[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
